// File: rtl/store_pkg.sv
// Shared encodings for the store path: access sizes, FSM state codes and
// byte-enable patterns used by the lane steering logic and the packer FSM.
package store_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_REQ  = 2'd1;
   localparam state_t ST_ERR  = 2'd2;

   localparam logic [3:0] BE_ALL     = 4'b1111;
   localparam logic [3:0] BE_LO_HALF = 4'b0011;
   localparam logic [3:0] BE_HI_HALF = 4'b1100;

endpackage

// File: rtl/store_lane_steer.sv
// Combinational lane steering: replicates the truncated store value across
// the 32-bit bus, picks the byte enables and flags misaligned/reserved sizes.
module store_lane_steer
   import store_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        misalign
);

   // Replication means memory only needs the enables to select the lane.
   always_comb begin
      wdata    = data;
      be       = BE_ALL;
      misalign = 1'b0;
      case (size)
         SZ_BYTE: begin
            wdata = {4{data[7:0]}};
            be    = 4'b0001 << addr_lo;
         end
         SZ_HALF: begin
            wdata    = {2{data[15:0]}};
            be       = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
            misalign = addr_lo[0];
         end
         SZ_WORD: begin
            wdata    = data;
            be       = BE_ALL;
            misalign = (addr_lo != 2'b00);
         end
         default: begin
            wdata    = data;
            be       = 4'b0000;
            misalign = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_lane_packer.sv
// Store-side datapath block: accepts a store from the control unit, drives a
// req/ack write to data memory and reports completion, misalignment or timeout.
module store_lane_packer
   import store_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic        done,
   output logic        err_misalign,
   output logic        err_timeout,
   output logic [31:0] err_addr
);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       addr_q;
   logic [31:0]       steer_wdata;
   logic [3:0]        steer_be;
   logic              steer_misalign;
   logic              accept;
   logic              timeout_hit;

   store_lane_steer u_steer (
      .size     (st_size),
      .addr_lo  (st_addr[1:0]),
      .data     (st_data),
      .wdata    (steer_wdata),
      .be       (steer_be),
      .misalign (steer_misalign)
   );

   assign accept      = (state == ST_IDLE) && st_valid && st_ready;
   assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // st_ready is registered so it only rises on the first edge after reset;
   // ack takes priority over a coincident timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         st_ready     <= 1'b0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_be       <= '0;
         err_addr     <= '0;
         addr_q       <= '0;
         cnt          <= '0;
         done         <= 1'b0;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         done         <= 1'b0;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  addr_q   <= st_addr;
                  cnt      <= '0;
                  st_ready <= 1'b0;
                  if (steer_misalign) begin
                     state        <= ST_ERR;
                     err_misalign <= 1'b1;
                     err_addr     <= st_addr;
                  end else begin
                     state     <= ST_REQ;
                     mem_req   <= 1'b1;
                     mem_addr  <= {st_addr[31:2], 2'b00};
                     mem_wdata <= steer_wdata;
                     mem_be    <= steer_be;
                  end
               end else begin
                  st_ready <= 1'b1;
               end
            end
            ST_REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (mem_ack) begin
                  state    <= ST_IDLE;
                  mem_req  <= 1'b0;
                  done     <= 1'b1;
                  st_ready <= 1'b1;
               end else if (timeout_hit) begin
                  state       <= ST_IDLE;
                  mem_req     <= 1'b0;
                  err_timeout <= 1'b1;
                  err_addr    <= addr_q;
                  st_ready    <= 1'b1;
               end
            end
            ST_ERR: begin
               state    <= ST_IDLE;
               st_ready <= 1'b1;
            end
            default: begin
               state    <= ST_IDLE;
               st_ready <= 1'b0;
               mem_req  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_lane_packer.sv
// Self-checking bench for store_lane_packer: table-driven stores plus
// hand-written timeout, back-to-back and mid-transaction reset sequences.
module tb_store_lane_packer;

   logic        clk;
   logic        rst_n;
   logic        st_valid;
   logic        st_ready;
   logic [1:0]  st_size;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        done;
   logic        err_misalign;
   logic        err_timeout;
   logic [31:0] err_addr;

   int checks;
   int failures;

   store_lane_packer #(.TIMEOUT_CYCLES(8), .CNT_W(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .st_valid     (st_valid),
      .st_ready     (st_ready),
      .st_size      (st_size),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_be       (mem_be),
      .mem_ack      (mem_ack),
      .done         (done),
      .err_misalign (err_misalign),
      .err_timeout  (err_timeout),
      .err_addr     (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
      int          ackDelay;
      bit          expMisalign;
      logic [31:0] expWdata;
      logic [3:0]  expBe;
   } vec_t;

   vec_t vecs [12];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic waitReady();
      int n;
      n = 0;
      @(negedge clk);
      while (!st_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ready_wait", {31'b0, st_ready}, 32'd1);
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [31:0] expAddr;
      expAddr = {v.addr[31:2], 2'b00};
      waitReady();
      st_valid = 1'b1;
      st_size  = v.size;
      st_addr  = v.addr;
      st_data  = v.data;
      @(posedge clk); #1;
      st_valid = 1'b0;
      if (v.expMisalign) begin
         checkOutput("misalign_pulse", {31'b0, err_misalign}, 32'd1);
         checkOutput("misalign_addr", err_addr, v.addr);
         checkOutput("misalign_noreq", {31'b0, mem_req}, 32'd0);
         checkOutput("misalign_ready", {31'b0, st_ready}, 32'd0);
         @(posedge clk); #1;
         checkOutput("misalign_end", {31'b0, err_misalign}, 32'd0);
         checkOutput("misalign_noreq2", {31'b0, mem_req}, 32'd0);
         checkOutput("misalign_idle", {31'b0, st_ready}, 32'd1);
      end else begin
         for (int k = 0; k <= v.ackDelay; k++) begin
            checkOutput("req_high", {31'b0, mem_req}, 32'd1);
            checkOutput("req_addr", mem_addr, expAddr);
            checkOutput("req_wdata", mem_wdata, v.expWdata);
            checkOutput("req_be", {28'b0, mem_be}, {28'b0, v.expBe});
            if (k == v.ackDelay) mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (k < v.ackDelay) checkOutput("done_early", {31'b0, done}, 32'd0);
         end
         checkOutput("done_pulse", {31'b0, done}, 32'd1);
         checkOutput("done_no_timeout", {31'b0, err_timeout}, 32'd0);
         checkOutput("done_req_low", {31'b0, mem_req}, 32'd0);
         checkOutput("done_ready", {31'b0, st_ready}, 32'd1);
         @(posedge clk); #1;
         checkOutput("done_single", {31'b0, done}, 32'd0);
      end
   endtask

   initial begin
      int n;
      checks   = 0;
      failures = 0;
      st_valid = 1'b0;
      st_size  = 2'b00;
      st_addr  = '0;
      st_data  = '0;
      mem_ack  = 1'b0;
      rst_n    = 1'b0;

      vecs[0]  = '{2'b00, 32'h0000_1003, 32'hAABB_CCDD, 0, 1'b0, 32'hDDDD_DDDD, 4'b1000};
      vecs[1]  = '{2'b01, 32'h0000_2002, 32'h1234_5678, 3, 1'b0, 32'h5678_5678, 4'b1100};
      vecs[2]  = '{2'b10, 32'h0000_3001, 32'hDEAD_BEEF, 0, 1'b1, 32'h0,         4'b0000};
      vecs[3]  = '{2'b11, 32'h0000_0000, 32'h0102_0304, 0, 1'b1, 32'h0,         4'b0000};
      vecs[4]  = '{2'b00, 32'h0000_1000, 32'h1122_3344, 0, 1'b0, 32'h4444_4444, 4'b0001};
      vecs[5]  = '{2'b00, 32'h0000_1001, 32'h1122_33A5, 1, 1'b0, 32'hA5A5_A5A5, 4'b0010};
      vecs[6]  = '{2'b01, 32'h0000_2000, 32'hFFFF_8001, 0, 1'b0, 32'h8001_8001, 4'b0011};
      vecs[7]  = '{2'b01, 32'h0000_2001, 32'h1234_5678, 0, 1'b1, 32'h0,         4'b0000};
      vecs[8]  = '{2'b10, 32'h0000_3000, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D, 4'b1111};
      vecs[9]  = '{2'b10, 32'h0000_3002, 32'h1111_2222, 0, 1'b1, 32'h0,         4'b0000};
      vecs[10] = '{2'b10, 32'h0000_6004, 32'h0BAD_F00D, 7, 1'b0, 32'h0BAD_F00D, 4'b1111};
      vecs[11] = '{2'b00, 32'h0000_1002, 32'h0000_007E, 2, 1'b0, 32'h7E7E_7E7E, 4'b0100};

      #2;
      checkOutput("rst_ready", {31'b0, st_ready}, 32'd0);
      checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
      checkOutput("rst_addr", mem_addr, 32'd0);
      checkOutput("rst_wdata", mem_wdata, 32'd0);
      checkOutput("rst_be", {28'b0, mem_be}, 32'd0);
      checkOutput("rst_erraddr", err_addr, 32'd0);
      checkOutput("rst_pulses", {29'b0, done, err_misalign, err_timeout}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_release_ready", {31'b0, st_ready}, 32'd0);
      @(posedge clk); #1;
      checkOutput("first_edge_ready", {31'b0, st_ready}, 32'd1);

      $display("[TB] table-driven stores");
      for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

      $display("[TB] timeout sequence");
      waitReady();
      st_valid = 1'b1;
      st_size  = 2'b10;
      st_addr  = 32'h0000_4000;
      st_data  = 32'h5555_AAAA;
      @(posedge clk); #1;
      st_valid = 1'b0;
      n = 0;
      while (mem_req && n < 20) begin
         n++;
         @(posedge clk); #1;
      end
      checkOutput("timeout_req_cycles", n, 32'd8);
      checkOutput("timeout_pulse", {31'b0, err_timeout}, 32'd1);
      checkOutput("timeout_no_done", {31'b0, done}, 32'd0);
      checkOutput("timeout_addr", err_addr, 32'h0000_4000);
      checkOutput("timeout_ready", {31'b0, st_ready}, 32'd1);
      @(posedge clk); #1;
      checkOutput("timeout_single", {31'b0, err_timeout}, 32'd0);

      $display("[TB] back-to-back sequence");
      waitReady();
      st_valid = 1'b1;
      st_size  = 2'b10;
      st_addr  = 32'h0000_5000;
      st_data  = 32'h1111_1111;
      mem_ack  = 1'b1;
      @(posedge clk); #1;
      checkOutput("b2b_req1", {31'b0, mem_req}, 32'd1);
      checkOutput("b2b_wdata1", mem_wdata, 32'h1111_1111);
      st_data = 32'h2222_2222;
      @(posedge clk); #1;
      checkOutput("b2b_done1", {31'b0, done}, 32'd1);
      checkOutput("b2b_ready1", {31'b0, st_ready}, 32'd1);
      @(posedge clk); #1;
      checkOutput("b2b_req2", {31'b0, mem_req}, 32'd1);
      checkOutput("b2b_wdata2", mem_wdata, 32'h2222_2222);
      checkOutput("b2b_gap", {31'b0, done}, 32'd0);
      st_valid = 1'b0;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      checkOutput("b2b_done2", {31'b0, done}, 32'd1);
      @(posedge clk); #1;
      checkOutput("b2b_idle_noreq", {31'b0, mem_req}, 32'd0);

      $display("[TB] reset during request");
      waitReady();
      st_valid = 1'b1;
      st_size  = 2'b10;
      st_addr  = 32'h0000_7000;
      st_data  = 32'h7777_7777;
      @(posedge clk); #1;
      st_valid = 1'b0;
      checkOutput("rstreq_req_high", {31'b0, mem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rstreq_async_drop", {31'b0, mem_req}, 32'd0);
      checkOutput("rstreq_ready", {31'b0, st_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rstreq_release_ready", {31'b0, st_ready}, 32'd0);
      @(posedge clk); #1;
      checkOutput("rstreq_edge_ready", {31'b0, st_ready}, 32'd1);
      checkOutput("rstreq_no_pulse", {29'b0, done, err_misalign, err_timeout}, 32'd0);
      checkOutput("rstreq_noreq", {31'b0, mem_req}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   always @(negedge clk) begin
      if (rst_n && ((done + err_misalign + err_timeout) > 1)) begin
         failures++;
         $display("[TB] FAIL pulse_exclusive done=%b misalign=%b timeout=%b", done, err_misalign, err_timeout);
      end
   end

endmodule

// File: doc/store_lane_packer.md
Name: store_lane_packer

Overview:
Store-side counterpart of the load-path sign extender in the single-cycle/multi-cycle CPU datapath.
- Takes a 32-bit register value plus store size (byte/half/word) and a byte address.
- Truncates the value to the requested width and replicates it onto the correct byte lanes of a 32-bit data-memory write bus, with byte enables.
- Drives a req/ack write transaction to data memory, and reports misalignment and timeout errors back to the control unit.

Parameters:
TIMEOUT_CYCLES, 16, max REQ cycles waiting for mem_ack before abort (must be >=1)
CNT_W, 5, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
st_valid  in  1  store request valid from control unit
st_ready  out  1  block can accept a store
st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
st_addr  in  32  byte address of store
st_data  in  32  register value to store (rt)
mem_req  out  1  write request to data memory
mem_addr  out  32  word-aligned address {st_addr[31:2],2'b00}
mem_wdata  out  32  lane-steered write data
mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
mem_ack  in  1  memory accepted write this cycle
done  out  1  one-cycle pulse: store completed
err_misalign  out  1  one-cycle pulse: misaligned or reserved-size store
err_timeout  out  1  one-cycle pulse: no ack within TIMEOUT_CYCLES
err_addr  out  32  st_addr of last errored store, held until next error

Behaviour:
- Reset state, asynchronous on rst_n low:
  - state=IDLE; st_ready=0; mem_req=0; mem_addr, mem_wdata, mem_be, err_addr = 0; done, err_misalign, err_timeout = 0; counter = 0.
  - st_ready rises on the first clk edge after rst_n deasserts.
- FSM states: IDLE, REQ, ERR.
- IDLE:
  - st_ready=1.
  - Accept when st_valid&&st_ready at an edge; latch addr/data/size.
  - Aligned request: go to REQ, register mem_addr/mem_wdata/mem_be, mem_req=1 from the next cycle.
  - Misaligned request: go to ERR.
- Alignment rules:
  - byte: always aligned.
  - half: st_addr[0] must be 0.
  - word: st_addr[1:0] must be 00.
  - size 11: always an error.
- Lane steering (upper bits of st_data discarded, no sign handling):
  - byte: wdata={4{data[7:0]}}, be=4'b0001<<addr[1:0].
  - half: wdata={2{data[15:0]}}, be = addr[1] ? 1100 : 0011.
  - word: wdata=data, be=1111.
- REQ:
  - st_ready=0.
  - mem_req, mem_addr, mem_wdata, mem_be held stable until ack.
  - Counter increments each REQ cycle.
  - mem_ack=1 at an edge: next state IDLE, mem_req=0, done=1 for one cycle (coincides with st_ready=1, so a new store may be accepted that same cycle).
  - Counter reaches TIMEOUT_CYCLES without ack: next state IDLE, mem_req=0, err_timeout=1 for one cycle, err_addr=latched addr.
  - Ack and timeout in the same cycle: ack wins, done only.
- ERR:
  - Lasts one cycle; st_ready=0, no mem_req ever issued.
  - err_misalign=1 and err_addr=latched addr, registered on the entry edge.
  - Next state IDLE.
- Latency and throughput: accept edge N gives mem_req high in cycle N+1. Best case is one store per 2 cycles (ack in first REQ cycle).
- mem_ack outside REQ is ignored.
- Reset mid-REQ: mem_req drops asynchronously; the transaction is abandoned with no done/err pulse.
- Mutual exclusion: done, err_misalign and err_timeout are never asserted together.

Decomposition:
- Shared package store_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - FSM state enum.
  - byte-enable constants BE_ALL, BE_LO_HALF, BE_HI_HALF.
- One combinational sub-module, store_lane_steer: inputs size and addr[1:0] plus data; outputs wdata, be and misalign.
- The top level holds the FSM, timeout counter and output registers.

Test Plan:
- Byte store, addr 0x00001003, data 0xAABBCCDD, ack in first REQ cycle -> mem_addr 0x00001000, wdata 0xDDDDDDDD, be 1000, done pulse 2 cycles after accept.
- Half store, addr 0x00002002, data 0x12345678, ack delayed 3 cycles -> wdata 0x56785678, be 1100, outputs stable all 4 REQ cycles, single done pulse after ack.
- Word store, addr 0x00003001 -> err_misalign pulse next cycle, err_addr 0x00003001, mem_req never high; size 11 at addr 0x0 -> err_misalign too.
- TIMEOUT_CYCLES=8, word store at 0x00004000, mem_ack held 0 -> mem_req high exactly 8 cycles, err_timeout pulse, err_addr 0x00004000, back in IDLE.
- Back-to-back: st_valid held high with two word stores, immediate acks -> second accepted in the done cycle, 2-cycle spacing, second wdata correct.
- rst_n pulsed low during REQ -> mem_req falls without clock, no done/err, st_ready 0 until first edge after release, then 1.
